load_store_buffer: RTL

- In-order circular queue for load and store instructions, between the dispatcher/reorder buffer and the memory-side load/store unit (LSU).
- Captures operands from the CDB (ALU and LSU broadcasts) and issues the head entry to the LSU only when it is safe to do so.
- Loads issue speculatively once their operands are ready, except IO loads.
- Stores and IO loads issue only after the reorder buffer commits them or marks them as the current head.

---
 rtl/load_store_buffer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_buffer.sv
// In-order load/store queue between dispatch and the LSU: snoops the CDBs for
// operands and issues the head entry once it is safe to touch memory.
module load_store_buffer #(
    parameter int          LSB_SIZE = 16,
    parameter int          ROB_ID_W = 5,
    parameter int          PTR_W    = 4,
    parameter logic [31:0] IO_BASE  = 32'h30000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                alloc_signal_from_dispatcher,
    input  logic                is_store_from_dispatcher,
    input  logic [2:0]          funct3_from_dispatcher,
    input  logic [ROB_ID_W-1:0] Q1_from_dispatcher,
    input  logic [ROB_ID_W-1:0] Q2_from_dispatcher,
    input  logic [31:0]         V1_from_dispatcher,
    input  logic [31:0]         V2_from_dispatcher,
    input  logic [31:0]         imm_from_dispatcher,
    input  logic [ROB_ID_W-1:0] rob_id_from_dispatcher,
    output logic                full_signal,
    input  logic                update_signal_from_alu,
    input  logic [ROB_ID_W-1:0] rob_id_from_alu,
    input  logic [31:0]         result_from_alu,
    input  logic                update_signal_from_lsu,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsu,
    input  logic [31:0]         result_from_lsu,
    input  logic                commit_flag_from_rob,
    input  logic [ROB_ID_W-1:0] rob_id_from_rob,
    input  logic [ROB_ID_W-1:0] io_rob_id_from_rob,
    input  logic                misbranch_flag,
    output logic [ROB_ID_W-1:0] io_ins_rob_id_to_rob,
    input  logic                lsu_busy,
    output logic                issue_valid_to_lsu,
    output logic                is_store_to_lsu,
    output logic [2:0]          funct3_to_lsu,
    output logic [31:0]         addr_to_lsu,
    output logic [31:0]         data_to_lsu,
    output logic [ROB_ID_W-1:0] rob_id_to_lsu
);

    // Entry storage (every entry is read by the snoop logic, so it lives in flops)
    logic [LSB_SIZE-1:0]               ent_busy_reg, ent_committed_reg, ent_is_store_reg;
    logic [LSB_SIZE-1:0][2:0]          ent_funct3_reg;
    logic [LSB_SIZE-1:0][ROB_ID_W-1:0] ent_q1_reg, ent_q2_reg, ent_rob_id_reg;
    logic [LSB_SIZE-1:0][31:0]         ent_v1_reg, ent_v2_reg, ent_imm_reg;

    logic [PTR_W-1:0]    head_reg, tail_reg, head_next, tail_next;
    logic [PTR_W:0]      count_reg, count_next, kept_count;
    logic                issue_valid_reg;
    logic                lsu_is_store_reg;
    logic [2:0]          lsu_funct3_reg;
    logic [31:0]         lsu_addr_reg, lsu_data_reg;
    logic [ROB_ID_W-1:0] lsu_rob_id_reg, io_ins_reg;

    // Per-entry next values after CDB snoop and commit
    logic [LSB_SIZE-1:0]               alu_hit1, alu_hit2, lsu_hit1, lsu_hit2;
    logic [LSB_SIZE-1:0]               commit_hit, committed_now, keep;
    logic [LSB_SIZE-1:0][ROB_ID_W-1:0] q1_snoop, q2_snoop;
    logic [LSB_SIZE-1:0][31:0]         v1_snoop, v2_snoop;

    logic pop, alloc_fire;

    genvar gi;
    generate
        for (gi = 0; gi < LSB_SIZE; gi++) begin : g_entry
            assign alu_hit1[gi] = update_signal_from_alu && (ent_q1_reg[gi] != '0) && (ent_q1_reg[gi] == rob_id_from_alu);
            assign alu_hit2[gi] = update_signal_from_alu && (ent_q2_reg[gi] != '0) && (ent_q2_reg[gi] == rob_id_from_alu);
            assign lsu_hit1[gi] = update_signal_from_lsu && (ent_q1_reg[gi] != '0) && (ent_q1_reg[gi] == rob_id_from_lsu);
            assign lsu_hit2[gi] = update_signal_from_lsu && (ent_q2_reg[gi] != '0) && (ent_q2_reg[gi] == rob_id_from_lsu);
            assign q1_snoop[gi] = (alu_hit1[gi] || lsu_hit1[gi]) ? '0 : ent_q1_reg[gi];
            assign q2_snoop[gi] = (alu_hit2[gi] || lsu_hit2[gi]) ? '0 : ent_q2_reg[gi];
            assign v1_snoop[gi] = alu_hit1[gi] ? result_from_alu : (lsu_hit1[gi] ? result_from_lsu : ent_v1_reg[gi]);
            assign v2_snoop[gi] = alu_hit2[gi] ? result_from_alu : (lsu_hit2[gi] ? result_from_lsu : ent_v2_reg[gi]);
            assign commit_hit[gi] = commit_flag_from_rob && ent_busy_reg[gi] && ent_is_store_reg[gi]
                                    && (ent_rob_id_reg[gi] == rob_id_from_rob);
            assign committed_now[gi] = ent_committed_reg[gi] | commit_hit[gi];
            // A misbranch keeps only committed stores; the issued head is always dropped
            assign keep[gi] = ent_busy_reg[gi]
                              && !(pop && (head_reg == PTR_W'(gi)))
                              && !(misbranch_flag && !committed_now[gi]);
        end
    endgenerate

    // Same-cycle forwarding for the entry being allocated
    logic                alloc_a1, alloc_a2, alloc_l1, alloc_l2;
    logic [ROB_ID_W-1:0] alloc_q1, alloc_q2;
    logic [31:0]         alloc_v1, alloc_v2;

    assign alloc_a1 = update_signal_from_alu && (Q1_from_dispatcher != '0) && (Q1_from_dispatcher == rob_id_from_alu);
    assign alloc_a2 = update_signal_from_alu && (Q2_from_dispatcher != '0) && (Q2_from_dispatcher == rob_id_from_alu);
    assign alloc_l1 = update_signal_from_lsu && (Q1_from_dispatcher != '0) && (Q1_from_dispatcher == rob_id_from_lsu);
    assign alloc_l2 = update_signal_from_lsu && (Q2_from_dispatcher != '0) && (Q2_from_dispatcher == rob_id_from_lsu);
    assign alloc_q1 = (alloc_a1 || alloc_l1) ? '0 : Q1_from_dispatcher;
    assign alloc_q2 = (alloc_a2 || alloc_l2) ? '0 : Q2_from_dispatcher;
    assign alloc_v1 = alloc_a1 ? result_from_alu : (alloc_l1 ? result_from_lsu : V1_from_dispatcher);
    assign alloc_v2 = alloc_a2 ? result_from_alu : (alloc_l2 ? result_from_lsu : V2_from_dispatcher);

    // Head entry view
    logic                head_busy, head_is_store, head_committed, head_is_io;
    logic                load_ready, store_ready, head_io_load;
    logic [ROB_ID_W-1:0] head_q1, head_q2, head_rob_id;
    logic [31:0]         head_addr;

    assign head_busy      = ent_busy_reg[head_reg];
    assign head_is_store  = ent_is_store_reg[head_reg];
    assign head_committed = ent_committed_reg[head_reg];
    assign head_q1        = ent_q1_reg[head_reg];
    assign head_q2        = ent_q2_reg[head_reg];
    assign head_rob_id    = ent_rob_id_reg[head_reg];
    assign head_addr      = ent_v1_reg[head_reg] + ent_imm_reg[head_reg];
    assign head_is_io     = (head_addr >= IO_BASE);

    assign head_io_load = (count_reg != '0) && head_busy && !head_is_store && (head_q1 == '0) && head_is_io;
    assign load_ready   = !head_is_store && (head_q1 == '0) && (!head_is_io || (io_rob_id_from_rob == head_rob_id));
    assign store_ready  = head_is_store && (head_q1 == '0) && (head_q2 == '0) && head_committed;

    // Loads never start during a flush; a committed store at the head still may
    assign pop = (count_reg != '0) && head_busy && !issue_valid_reg && !lsu_busy
                 && (misbranch_flag ? store_ready : (load_ready || store_ready));
    assign alloc_fire = alloc_signal_from_dispatcher && !misbranch_flag;

    always_comb begin
        kept_count = '0;
        for (int i = 0; i < LSB_SIZE; i++) begin
            if (ent_busy_reg[i] && committed_now[i]) begin
                kept_count = kept_count + (PTR_W+1)'(1);
            end
        end
    end

    always_comb begin
        head_next  = head_reg + PTR_W'(pop);
        tail_next  = tail_reg + PTR_W'(alloc_fire);
        count_next = count_reg + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(pop);
        if (misbranch_flag) begin
            tail_next  = head_reg + kept_count[PTR_W-1:0];
            count_next = kept_count - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            ent_busy_reg      <= '0;
            ent_committed_reg <= '0;
            issue_valid_reg   <= 1'b0;
            io_ins_reg        <= '0;
            lsu_is_store_reg  <= 1'b0;
            lsu_funct3_reg    <= '0;
            lsu_addr_reg      <= '0;
            lsu_data_reg      <= '0;
            lsu_rob_id_reg    <= '0;
        end else if (rdy) begin
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
            issue_valid_reg <= pop;
            io_ins_reg      <= head_io_load ? head_rob_id : '0;
            if (pop) begin
                lsu_is_store_reg <= head_is_store;
                lsu_funct3_reg   <= ent_funct3_reg[head_reg];
                lsu_addr_reg     <= head_addr;
                lsu_data_reg     <= ent_v2_reg[head_reg];
                lsu_rob_id_reg   <= head_rob_id;
            end
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (alloc_fire && (tail_reg == PTR_W'(i))) begin
                    ent_busy_reg[i]      <= 1'b1;
                    ent_committed_reg[i] <= 1'b0;
                    ent_is_store_reg[i]  <= is_store_from_dispatcher;
                    ent_funct3_reg[i]    <= funct3_from_dispatcher;
                    ent_q1_reg[i]        <= alloc_q1;
                    ent_q2_reg[i]        <= alloc_q2;
                    ent_v1_reg[i]        <= alloc_v1;
                    ent_v2_reg[i]        <= alloc_v2;
                    ent_imm_reg[i]       <= imm_from_dispatcher;
                    ent_rob_id_reg[i]    <= rob_id_from_dispatcher;
                end else begin
                    ent_busy_reg[i]      <= keep[i];
                    ent_committed_reg[i] <= committed_now[i] & keep[i];
                    ent_q1_reg[i]        <= q1_snoop[i];
                    ent_q2_reg[i]        <= q2_snoop[i];
                    ent_v1_reg[i]        <= v1_snoop[i];
                    ent_v2_reg[i]        <= v2_snoop[i];
                end
            end
        end
    end

    assign full_signal          = (count_reg >= (PTR_W+1)'(LSB_SIZE - 3));
    assign issue_valid_to_lsu   = issue_valid_reg;
    assign is_store_to_lsu      = lsu_is_store_reg;
    assign funct3_to_lsu        = lsu_funct3_reg;
    assign addr_to_lsu          = lsu_addr_reg;
    assign data_to_lsu          = lsu_data_reg;
    assign rob_id_to_lsu        = lsu_rob_id_reg;
    assign io_ins_rob_id_to_rob = io_ins_reg;

endmodule
